// File: rtl/framebuffer_scanout.sv
// HUB75 scan-out: reads RGB565 row pairs from frame memory port B and drives the panel
// with binary-coded modulation over PLANES bit-planes.
module framebuffer_scanout #(
    parameter int unsigned COLUMNS      = 64,
    parameter int unsigned ROWS         = 32,
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned ROW_W        = 4,
    parameter int unsigned PLANES       = 4,
    parameter int unsigned DISPLAY_BASE = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    output logic [ADDR_W-1:0] o_mem_addr_b,
    output logic              o_mem_en_b,
    input  logic [15:0]       i_mem_data_b,
    output logic [ROW_W-1:0]  o_row_addr,
    output logic [2:0]        o_rgb0,
    output logic [2:0]        o_rgb1,
    output logic              o_panel_clk,
    output logic              o_panel_lat,
    output logic              o_panel_oe_n,
    output logic              o_frame_start
);

    localparam int unsigned SHIFT_LEN = 4 * COLUMNS + 2;
    localparam int unsigned DISP_MAX  = DISPLAY_BASE << (PLANES - 1);
    localparam int unsigned CNT_W     = $clog2(((SHIFT_LEN > DISP_MAX) ? SHIFT_LEN : DISP_MAX) + 1);
    localparam int unsigned PLANE_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int unsigned HALF_OFF  = (ROWS / 2) * COLUMNS;

    typedef enum logic [2:0] {StIdle, StShift, StBlank, StLatch, StDisplay} state_e;

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ROW_W-1:0]    r_row;
    logic [PLANE_W-1:0]  r_plane;
    logic [15:0]         r_upper;
    logic [15:0]         r_lower;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_en;
    logic [ROW_W-1:0]    r_row_addr;
    logic [2:0]          r_rgb0;
    logic [2:0]          r_rgb1;
    logic                r_panel_clk;
    logic                r_panel_lat;
    logic                r_panel_oe_n;
    logic                r_frame_start;

    // Selects the top PLANES bits of each channel: R=w[16-P+p], G=w[11-P+p], B=w[5-P+p].
    function automatic logic [2:0] plane_bits(input logic [15:0] w, input logic [PLANE_W-1:0] p);
        logic [15:0] sh_r;
        logic [15:0] sh_g;
        logic [15:0] sh_b;
        sh_r = w >> (32'(16 - PLANES) + 32'(p));
        sh_g = w >> (32'(11 - PLANES) + 32'(p));
        sh_b = w >> (32'(5 - PLANES) + 32'(p));
        return {sh_r[0], sh_g[0], sh_b[0]};
    endfunction

    // Outputs are registered, so SHIFT decodes the slot/phase of the *next* cycle.
    logic [CNT_W-1:0]   w_k1;
    logic [CNT_W-1:0]   w_col;
    logic [1:0]         w_phase;
    logic               w_slot_mem;
    logic [ADDR_W-1:0]  w_row_base;
    logic [ADDR_W-1:0]  w_addr_up;
    logic [ADDR_W-1:0]  w_addr_lo;
    logic               w_last_plane;
    logic [PLANE_W-1:0] w_plane_nxt;
    logic [ROW_W-1:0]   w_row_nxt;
    logic               w_shift_end;
    logic               w_disp_end;

    assign w_k1         = r_cnt + CNT_W'(1);
    assign w_col        = w_k1 >> 2;
    assign w_phase      = w_k1[1:0];
    assign w_slot_mem   = (w_col < CNT_W'(COLUMNS)) && !w_phase[1];
    assign w_row_base   = ADDR_W'(r_row) * ADDR_W'(COLUMNS);
    assign w_addr_up    = w_row_base + ADDR_W'(w_col);
    assign w_addr_lo    = w_addr_up + ADDR_W'(HALF_OFF);
    assign w_last_plane = (r_plane == PLANE_W'(PLANES - 1));
    assign w_plane_nxt  = w_last_plane ? '0 : r_plane + PLANE_W'(1);
    assign w_row_nxt    = !w_last_plane ? r_row :
                          (r_row == ROW_W'(ROWS / 2 - 1)) ? '0 : r_row + ROW_W'(1);
    assign w_shift_end  = (r_cnt == CNT_W'(SHIFT_LEN - 1));
    assign w_disp_end   = (r_cnt == (CNT_W'(DISPLAY_BASE) << r_plane) - CNT_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_row         <= '0;
            r_plane       <= '0;
            r_upper       <= '0;
            r_lower       <= '0;
            r_mem_addr    <= '0;
            r_mem_en      <= 1'b0;
            r_row_addr    <= '0;
            r_rgb0        <= '0;
            r_rgb1        <= '0;
            r_panel_clk   <= 1'b0;
            r_panel_lat   <= 1'b0;
            r_panel_oe_n  <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_enable) begin
                        r_state       <= StShift;
                        r_cnt         <= '0;
                        r_mem_en      <= 1'b1;
                        r_mem_addr    <= w_row_base;
                        r_frame_start <= (r_row == '0) && (r_plane == '0);
                    end
                end
                StShift: begin
                    case (r_cnt[1:0])
                        2'd1: r_upper <= i_mem_data_b;
                        2'd2: r_lower <= i_mem_data_b;
                        2'd3: begin
                            r_rgb0 <= plane_bits(r_upper, r_plane);
                            r_rgb1 <= plane_bits(r_lower, r_plane);
                        end
                        default: ;
                    endcase
                    if (w_shift_end) begin
                        r_state     <= StBlank;
                        r_cnt       <= '0;
                        r_panel_clk <= 1'b0;
                        r_mem_en    <= 1'b0;
                        r_row_addr  <= r_row;
                    end else begin
                        r_cnt       <= w_k1;
                        r_mem_en    <= w_slot_mem;
                        r_panel_clk <= (w_col != '0) && !w_phase[1];
                        if (w_slot_mem) r_mem_addr <= w_phase[0] ? w_addr_lo : w_addr_up;
                    end
                end
                StBlank: begin
                    r_state     <= StLatch;
                    r_panel_lat <= 1'b1;
                end
                StLatch: begin
                    r_state      <= StDisplay;
                    r_panel_lat  <= 1'b0;
                    r_panel_oe_n <= 1'b0;
                    r_cnt        <= '0;
                end
                StDisplay: begin
                    if (w_disp_end) begin
                        r_panel_oe_n <= 1'b1;
                        r_cnt        <= '0;
                        if (i_enable) begin
                            r_state       <= StShift;
                            r_plane       <= w_plane_nxt;
                            r_row         <= w_row_nxt;
                            r_mem_en      <= 1'b1;
                            r_mem_addr    <= ADDR_W'(w_row_nxt) * ADDR_W'(COLUMNS);
                            r_frame_start <= (w_row_nxt == '0) && (w_plane_nxt == '0);
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_cnt <= w_k1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_mem_addr_b  = r_mem_addr;
    assign o_mem_en_b    = r_mem_en;
    assign o_row_addr    = r_row_addr;
    assign o_rgb0        = r_rgb0;
    assign o_rgb1        = r_rgb1;
    assign o_panel_clk   = r_panel_clk;
    assign o_panel_lat   = r_panel_lat;
    assign o_panel_oe_n  = r_panel_oe_n;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: a per-cycle timeline model of one row/plane pass, checked
// against the DUT with a synchronous-read memory model on port B.
module tb_framebuffer_scanout;

    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int AW   = 4;
    localparam int RW   = 1;
    localparam int PL   = 2;
    localparam int DB   = 4;
    localparam int HALF = (ROWS / 2) * COLS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] addr;
    logic          en;
    logic [15:0]   rdata = 16'h0;
    logic [RW-1:0] row_addr;
    logic [2:0]    rgb0;
    logic [2:0]    rgb1;
    logic          pclk;
    logic          plat;
    logic          poe_n;
    logic          fs;

    logic [15:0]   mem [16];
    int            checks = 0;
    int            errors = 0;
    int            q_addr [$];

    // Model state for outputs that hold between updates.
    logic [AW-1:0] m_addr;
    logic [2:0]    m_rgb0;
    logic [2:0]    m_rgb1;
    logic [RW-1:0] m_row;

    always #5 clk = ~clk;

    always @(posedge clk) if (en) rdata <= mem[addr];

    framebuffer_scanout #(
        .COLUMNS      (COLS),
        .ROWS         (ROWS),
        .ADDR_W       (AW),
        .ROW_W        (RW),
        .PLANES       (PL),
        .DISPLAY_BASE (DB)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .o_mem_addr_b  (addr),
        .o_mem_en_b    (en),
        .i_mem_data_b  (rdata),
        .o_row_addr    (row_addr),
        .o_rgb0        (rgb0),
        .o_rgb1        (rgb1),
        .o_panel_clk   (pclk),
        .o_panel_lat   (plat),
        .o_panel_oe_n  (poe_n),
        .o_frame_start (fs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] plane_bits(input logic [15:0] w, input int p);
        logic [15:0] sr;
        logic [15:0] sg;
        logic [15:0] sb;
        sr = w >> (16 - PL + p);
        sg = w >> (11 - PL + p);
        sb = w >> (5 - PL + p);
        return {sr[0], sg[0], sb[0]};
    endfunction

    function automatic logic [15:0] pack_obs();
        return {addr, en, row_addr, rgb0, rgb1, pclk, plat, poe_n, fs};
    endfunction

    function automatic logic [15:0] pack_exp(input logic e_en, input logic e_clk,
                                             input logic e_lat, input logic e_oe, input logic e_fs);
        return {m_addr, e_en, m_row, m_rgb0, m_rgb1, e_clk, e_lat, e_oe, e_fs};
    endfunction

    task automatic reset_model();
        m_addr = '0;
        m_rgb0 = '0;
        m_rgb1 = '0;
        m_row  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        reset_model();
        #1;
        check("reset_async", 32'(pack_obs()), 32'(pack_exp(0, 0, 0, 1, 0)));
        @(negedge clk);
        check("reset_hold", 32'(pack_obs()), 32'(pack_exp(0, 0, 0, 1, 0)));
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", tag, i), 32'(pack_obs()), 32'(pack_exp(0, 0, 0, 1, 0)));
        end
    endtask

    // One full SHIFT(4*COLS+2) + BLANK + LATCH + DISPLAY(DB<<plane) pass.
    task automatic run_pass(input int row, input int plane, input int drop_k,
                            output int n_fs, output int n_hi, output int n_rise, output int n_oe);
        int   total;
        int   col;
        int   ph;
        logic e_en, e_clk, e_lat, e_oe, e_fs;
        logic prev_clk;
        total    = 4 * COLS + 2 + 2 + (DB << plane);
        n_fs     = 0;
        n_hi     = 0;
        n_rise   = 0;
        n_oe     = 0;
        prev_clk = 1'b0;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            e_en = 0; e_clk = 0; e_lat = 0; e_oe = 1; e_fs = 0;
            if (k < 4 * COLS + 2) begin
                col = k / 4;
                ph  = k % 4;
                if (col < COLS && ph < 2) begin
                    e_en   = 1;
                    m_addr = AW'((ph == 0 ? 0 : HALF) + row * COLS + col);
                end
                if (k >= 4 && ph < 2) e_clk = 1;
                if (k >= 4 && ph == 0) begin
                    m_rgb0 = plane_bits(mem[row * COLS + col - 1], plane);
                    m_rgb1 = plane_bits(mem[HALF + row * COLS + col - 1], plane);
                end
                e_fs = (k == 0 && row == 0 && plane == 0);
            end else if (k == 4 * COLS + 2) begin
                m_row = RW'(row);
            end else if (k == 4 * COLS + 3) begin
                e_lat = 1;
            end else begin
                e_oe = 0;
            end
            check($sformatf("r%0d p%0d k%0d", row, plane, k), 32'(pack_obs()),
                  32'(pack_exp(e_en, e_clk, e_lat, e_oe, e_fs)));
            if (en === 1'b1) q_addr.push_back(int'(addr));
            if (fs === 1'b1) n_fs++;
            if (pclk === 1'b1) n_hi++;
            if (pclk === 1'b1 && prev_clk === 1'b0) n_rise++;
            if (poe_n === 1'b0) n_oe++;
            prev_clk = pclk;
            if (k == drop_k) enable = 1'b0;
        end
    endtask

    initial begin
        int n_fs, n_hi, n_rise, n_oe;
        int exp_addr [8];
        exp_addr = '{0, 8, 1, 9, 2, 10, 3, 11};

        // Reset and idle.
        do_reset();
        check_idle(20, "idle");

        // Address sequence, clock pulses and frame start with word[a]=a.
        for (int a = 0; a < 16; a++) mem[a] = 16'(a);
        do_reset();
        enable = 1'b1;
        q_addr.delete();
        run_pass(0, 0, 0, n_fs, n_hi, n_rise, n_oe);
        check("t2_fs_count", 32'(n_fs), 32'd1);
        check("t2_clk_rises", 32'(n_rise), 32'd4);
        check("t2_clk_high", 32'(n_hi), 32'd8);
        check("t2_addr_count", 32'(q_addr.size()), 32'd8);
        for (int i = 0; i < 8 && i < q_addr.size(); i++)
            check($sformatf("t2_addr%0d", i), 32'(q_addr[i]), 32'(exp_addr[i]));
        check_idle(3, "t2_idle");

        // All ones: both planes light every channel; display lengths 4 then 8.
        for (int a = 0; a < 16; a++) mem[a] = 16'hFFFF;
        do_reset();
        enable = 1'b1;
        run_pass(0, 0, -1, n_fs, n_hi, n_rise, n_oe);
        check("t3_rgb_p0", 32'({rgb0, rgb1}), 32'h3F);
        check("t3_oe_p0", 32'(n_oe), 32'd4);
        run_pass(0, 1, 0, n_fs, n_hi, n_rise, n_oe);
        check("t3_rgb_p1", 32'({rgb0, rgb1}), 32'h3F);
        check("t3_oe_p1", 32'(n_oe), 32'd8);
        check_idle(3, "t3_idle");

        // Only channel MSBs set: dark on plane 0, lit on plane 1.
        for (int a = 0; a < 16; a++) mem[a] = 16'h8410;
        do_reset();
        enable = 1'b1;
        run_pass(0, 0, -1, n_fs, n_hi, n_rise, n_oe);
        check("t4_rgb_p0", 32'({rgb0, rgb1}), 32'h00);
        run_pass(0, 1, 0, n_fs, n_hi, n_rise, n_oe);
        check("t4_rgb_p1", 32'({rgb0, rgb1}), 32'h3F);
        check_idle(2, "t4_idle");

        // Random image, full frame plus wrap; Enable dropped mid-shift on the last pass.
        for (int a = 0; a < 16; a++) mem[a] = 16'($urandom);
        do_reset();
        enable = 1'b1;
        run_pass(0, 0, -1, n_fs, n_hi, n_rise, n_oe);
        check("t5_fs_first", 32'(n_fs), 32'd1);
        run_pass(0, 1, -1, n_fs, n_hi, n_rise, n_oe);
        run_pass(1, 0, -1, n_fs, n_hi, n_rise, n_oe);
        check("t5_fs_row1", 32'(n_fs), 32'd0);
        run_pass(1, 1, -1, n_fs, n_hi, n_rise, n_oe);
        run_pass(0, 0, 6, n_fs, n_hi, n_rise, n_oe);
        check("t5_fs_wrap", 32'(n_fs), 32'd1);
        check_idle(5, "t5_idle");

        // Asynchronous reset during column 2, then restart from row 0 plane 0.
        for (int a = 0; a < 16; a++) mem[a] = 16'($urandom);
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 8) check("t6_pre_addr", 32'({en, addr}), 32'({1'b1, 4'd2}));
        end
        #1 rst_n = 1'b0;
        reset_model();
        #1;
        check("t6_reset_now", 32'(pack_obs()), 32'(pack_exp(0, 0, 0, 1, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(0, 0, 0, n_fs, n_hi, n_rise, n_oe);
        check("t6_restart_fs", 32'(n_fs), 32'd1);
        check_idle(3, "t6_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
